// File: rtl/sm_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined sign-magnitude adder/subtractor.
// master = operand producer / result consumer side, slave = the pipeline itself.
interface sm_addsub_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             sub;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             ovf;
   logic             zero;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, op1, op2, sub, in_tag, out_ready,
      input  in_ready, out_valid, res, ovf, zero, out_tag
   );

   modport slave (
      input  in_valid, op1, op2, sub, in_tag, out_ready,
      output in_ready, out_valid, res, ovf, zero, out_tag
   );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Three-stage sign-magnitude add/subtract: SM->TC convert, (WIDTH+1)-bit TC add,
// TC->SM convert with overflow clamp or wrap and canonical (positive) zero.
module sm_addsub_pipe #(
   parameter int WIDTH    = 32,
   parameter int TAG_W    = 4,
   parameter int SATURATE = 1
) (
   input logic             clk,
   input logic             rst_n,
   sm_addsub_pipe_if.slave bus
);

   localparam logic [WIDTH:0]   TC_ONE  = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAG_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic             SAT_EN  = (SATURATE != 32'sd0);

   // Negative zero collapses to 0 because ~0 + 1 wraps back to 0 at this width.
   function automatic logic [WIDTH:0] sm_to_tc(input logic sign, input logic [WIDTH-2:0] mag);
      logic [WIDTH:0] ext;
      ext = {2'b00, mag};
      if (sign) begin
         sm_to_tc = ~ext + TC_ONE;
      end else begin
         sm_to_tc = ext;
      end
   endfunction

   logic             advance_s;
   logic             b_sign_s;
   logic [WIDTH:0]   a_tc_s;
   logic [WIDTH:0]   b_tc_s;

   logic             v1_r;
   logic             v2_r;
   logic             v3_r;
   logic [WIDTH:0]   a_tc_r;
   logic [WIDTH:0]   b_tc_r;
   logic [WIDTH:0]   sum_r;
   logic [TAG_W-1:0] tag1_r;
   logic [TAG_W-1:0] tag2_r;
   logic [TAG_W-1:0] tag3_r;

   logic             sign_s;
   logic [WIDTH-1:0] mag_s;
   logic [WIDTH-2:0] mag_out_s;
   logic             ovf_nxt_s;
   logic             zero_nxt_s;
   logic [WIDTH-1:0] res_nxt_s;

   logic [WIDTH-1:0] res_r;
   logic             ovf_r;
   logic             zero_r;

   // The whole pipe moves together; only a held result at the output stalls it.
   assign advance_s     = bus.out_ready | ~v3_r;
   assign bus.in_ready  = advance_s;
   assign bus.out_valid = v3_r;
   assign bus.res       = res_r;
   assign bus.ovf       = ovf_r;
   assign bus.zero      = zero_r;
   assign bus.out_tag   = tag3_r;

   // Stage 1 operand conversion; subtraction flips the sign of op2.
   always_comb begin
      b_sign_s = bus.op2[WIDTH-1] ^ bus.sub;
      a_tc_s   = sm_to_tc(bus.op1[WIDTH-1], bus.op1[WIDTH-2:0]);
      b_tc_s   = sm_to_tc(b_sign_s, bus.op2[WIDTH-2:0]);
   end

   // Stage 3 conversion back to sign-magnitude. |sum| < 2^WIDTH, so the low WIDTH
   // bits of the negated sum are the exact magnitude.
   always_comb begin
      sign_s = sum_r[WIDTH];
      if (sign_s) begin
         mag_s = ~sum_r[WIDTH-1:0] + MAG_ONE;
      end else begin
         mag_s = sum_r[WIDTH-1:0];
      end
      ovf_nxt_s = mag_s[WIDTH-1];
      if (ovf_nxt_s && SAT_EN) begin
         mag_out_s = {(WIDTH-1){1'b1}};
      end else begin
         mag_out_s = mag_s[WIDTH-2:0];
      end
      zero_nxt_s = (mag_out_s == {(WIDTH-1){1'b0}});
      if (zero_nxt_s) begin
         res_nxt_s = {WIDTH{1'b0}};
      end else begin
         res_nxt_s = {sign_s, mag_out_s};
      end
   end

   // Pipeline registers: cleared by reset, frozen as a whole while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_r   <= 1'b0;
         v2_r   <= 1'b0;
         v3_r   <= 1'b0;
         a_tc_r <= {(WIDTH+1){1'b0}};
         b_tc_r <= {(WIDTH+1){1'b0}};
         sum_r  <= {(WIDTH+1){1'b0}};
         tag1_r <= {TAG_W{1'b0}};
         tag2_r <= {TAG_W{1'b0}};
         tag3_r <= {TAG_W{1'b0}};
         res_r  <= {WIDTH{1'b0}};
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else if (advance_s) begin
         v1_r   <= bus.in_valid;
         a_tc_r <= a_tc_s;
         b_tc_r <= b_tc_s;
         tag1_r <= bus.in_tag;

         v2_r   <= v1_r;
         sum_r  <= a_tc_r + b_tc_r;
         tag2_r <= tag1_r;

         v3_r   <= v2_r;
         res_r  <= res_nxt_s;
         ovf_r  <= ovf_nxt_s;
         zero_r <= zero_nxt_s;
         tag3_r <= tag2_r;
      end else begin
         v1_r <= v1_r;
         v2_r <= v2_r;
         v3_r <= v3_r;
      end
   end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed and randomised checks of sm_addsub_pipe: 32-bit clamp/wrap pair for
// directed vectors, 8-bit clamp/wrap pair for a sweep against a reference model.
module tb_sm_addsub_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   sm_addsub_pipe_if #(.WIDTH(32), .TAG_W(4)) a_if ();
   sm_addsub_pipe_if #(.WIDTH(32), .TAG_W(4)) b_if ();
   sm_addsub_pipe_if #(.WIDTH(8),  .TAG_W(4)) c_if ();
   sm_addsub_pipe_if #(.WIDTH(8),  .TAG_W(4)) d_if ();

   sm_addsub_pipe #(.WIDTH(32), .TAG_W(4), .SATURATE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   sm_addsub_pipe #(.WIDTH(32), .TAG_W(4), .SATURATE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
   sm_addsub_pipe #(.WIDTH(8),  .TAG_W(4), .SATURATE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));
   sm_addsub_pipe #(.WIDTH(8),  .TAG_W(4), .SATURATE(0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(d_if.slave));

   typedef struct {
      logic [7:0] rs;
      logic       os;
      logic       zs;
      logic [7:0] rw;
      logic       ow;
      logic       zw;
      logic [3:0] tg;
   } exp8_t;

   exp8_t      q8[$];
   int         got;
   logic       acc;
   logic [7:0] o1_8;
   logic [7:0] o2_8;
   logic       s_8;
   logic [3:0] t_8;
   logic       iv_8;
   logic       or_8;

   task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      tests_run++;
      if (got_v !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic drive32(input logic v, input logic [31:0] o1, input logic [31:0] o2,
                          input logic s, input logic [3:0] t);
      a_if.in_valid = v; a_if.op1 = o1; a_if.op2 = o2; a_if.sub = s; a_if.in_tag = t;
      b_if.in_valid = v; b_if.op1 = o1; b_if.op2 = o2; b_if.sub = s; b_if.in_tag = t;
   endtask

   task automatic set_ordy32(input logic r);
      a_if.out_ready = r;
      b_if.out_ready = r;
   endtask

   task automatic drive8(input logic v, input logic [7:0] o1, input logic [7:0] o2,
                         input logic s, input logic [3:0] t);
      c_if.in_valid = v; c_if.op1 = o1; c_if.op2 = o2; c_if.sub = s; c_if.in_tag = t;
      d_if.in_valid = v; d_if.op1 = o1; d_if.op2 = o2; d_if.sub = s; d_if.in_tag = t;
   endtask

   task automatic set_ordy8(input logic r);
      c_if.out_ready = r;
      d_if.out_ready = r;
   endtask

   task automatic idle32(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive32(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
         set_ordy32(1'b1);
      end
   endtask

   task automatic chk_out32(input string nm, input logic [3:0] t,
                            input logic [31:0] ra, input logic oa, input logic za,
                            input logic [31:0] rb, input logic ob, input logic zb);
      check_eq({nm, "_a_valid"}, 32'(a_if.out_valid), 32'd1);
      check_eq({nm, "_a_res"},   a_if.res,             ra);
      check_eq({nm, "_a_ovf"},   32'(a_if.ovf),        32'(oa));
      check_eq({nm, "_a_zero"},  32'(a_if.zero),       32'(za));
      check_eq({nm, "_a_tag"},   32'(a_if.out_tag),    32'(t));
      check_eq({nm, "_b_valid"}, 32'(b_if.out_valid), 32'd1);
      check_eq({nm, "_b_res"},   b_if.res,             rb);
      check_eq({nm, "_b_ovf"},   32'(b_if.ovf),        32'(ob));
      check_eq({nm, "_b_zero"},  32'(b_if.zero),       32'(zb));
      check_eq({nm, "_b_tag"},   32'(b_if.out_tag),    32'(t));
   endtask

   // One isolated transaction: out_valid must be low after edges 1 and 2, high after edge 3.
   task automatic single32(input string nm, input logic [31:0] o1, input logic [31:0] o2,
                           input logic s, input logic [3:0] t,
                           input logic [31:0] ra, input logic oa, input logic za,
                           input logic [31:0] rb, input logic ob, input logic zb);
      @(negedge clk);
      drive32(1'b1, o1, o2, s, t);
      set_ordy32(1'b1);
      #1 check_eq({nm, "_in_ready"}, 32'(a_if.in_ready), 32'd1);
      @(posedge clk); #1;
      drive32(1'b0, o1, o2, s, t);
      check_eq({nm, "_lat1"}, 32'(a_if.out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq({nm, "_lat2"}, 32'(a_if.out_valid), 32'd0);
      @(posedge clk); #1;
      chk_out32(nm, t, ra, oa, za, rb, ob, zb);
   endtask

   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input logic sat);
      int         va;
      int         vb;
      int         sm;
      int         mg;
      logic       ng;
      logic       ov;
      logic [7:0] r;
      va = int'(a[6:0]);
      if (a[7]) va = -va;
      vb = int'(b[6:0]);
      if (b[7] ^ s) vb = -vb;
      sm = va + vb;
      ng = (sm < 0);
      mg = ng ? -sm : sm;
      ov = (mg > 127);
      if (ov && sat) r = {ng, 7'h7f};
      else           r = {ng, 7'(mg % 128)};
      if (r[6:0] == 7'h00) r[7] = 1'b0;
      return {ov, (r[6:0] == 7'h00), r};
   endfunction

   task automatic gen_sm8(output logic [7:0] v);
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
         0:       v = {1'($urandom_range(0, 1)), 7'h00};
         1:       v = {1'($urandom_range(0, 1)), 7'h7f};
         default: v = 8'($urandom_range(0, 255));
      endcase
   endtask

   task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
      exp8_t      e;
      logic [9:0] m;
      m = model8(a, b, s, 1'b1);
      e.rs = m[7:0]; e.zs = m[8]; e.os = m[9];
      m = model8(a, b, s, 1'b0);
      e.rw = m[7:0]; e.zw = m[8]; e.ow = m[9];
      e.tg = t;
      q8.push_back(e);
   endtask

   task automatic chk8_pop();
      exp8_t e;
      if (q8.size() == 0) begin
         check_eq("sw_extra", 32'(c_if.out_valid), 32'd0);
      end else begin
         e = q8.pop_front();
         check_eq("sw_c_res",   32'(c_if.res),       32'(e.rs));
         check_eq("sw_c_ovf",   32'(c_if.ovf),       32'(e.os));
         check_eq("sw_c_zero",  32'(c_if.zero),      32'(e.zs));
         check_eq("sw_c_tag",   32'(c_if.out_tag),   32'(e.tg));
         check_eq("sw_d_valid", 32'(d_if.out_valid), 32'd1);
         check_eq("sw_d_res",   32'(d_if.res),       32'(e.rw));
         check_eq("sw_d_ovf",   32'(d_if.ovf),       32'(e.ow));
         check_eq("sw_d_zero",  32'(d_if.zero),      32'(e.zw));
         check_eq("sw_d_tag",   32'(d_if.out_tag),   32'(e.tg));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0;
      drive32(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      set_ordy32(1'b1);
      drive8(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      set_ordy8(1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_out_valid", 32'(a_if.out_valid), 32'd0);
      check_eq("rst_res",       a_if.res,            32'h0);
      check_eq("rst_ovf",       32'(a_if.ovf),       32'd0);
      check_eq("rst_zero",      32'(a_if.zero),      32'd0);
      check_eq("rst_tag",       32'(a_if.out_tag),   32'd0);
      check_eq("rst_in_ready",  32'(a_if.in_ready),  32'd1);
      check_eq("rst_c_valid",   32'(c_if.out_valid), 32'd0);

      single32("sub_5_m3",  32'h00000005, 32'h80000003, 1'b1, 4'hA, 32'h00000008, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0);
      single32("add_3_m5",  32'h00000003, 32'h80000005, 1'b0, 4'h1, 32'h80000002, 1'b0, 1'b0, 32'h80000002, 1'b0, 1'b0);
      single32("negzero",   32'h80000000, 32'h00000000, 1'b0, 4'h2, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
      single32("sub_nn",    32'h80000007, 32'h80000007, 1'b1, 4'h3, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
      single32("add_nn",    32'h80000010, 32'h80000020, 1'b0, 4'h4, 32'h80000030, 1'b0, 1'b0, 32'h80000030, 1'b0, 1'b0);
      single32("max_exact", 32'h7FFFFFFE, 32'h00000001, 1'b0, 4'h7, 32'h7FFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
      single32("ovf_pos",   32'h7FFFFFFF, 32'h00000001, 1'b0, 4'h5, 32'h7FFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1);
      single32("ovf_neg",   32'hFFFFFFFF, 32'h00000001, 1'b1, 4'h6, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1);

      // Backpressure: three ops fill the pipe, the fourth waits behind a held result.
      idle32(2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive32(1'b1, 32'(k + 1), 32'h10, 1'b0, 4'(k));
         set_ordy32(1'b0);
         #1 check_eq("bp_fill_ready", 32'(a_if.in_ready), 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      drive32(1'b1, 32'h4, 32'h10, 1'b0, 4'h3);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            @(negedge clk); #1;
         end
         check_eq("bp_in_ready", 32'(a_if.in_ready),  32'd0);
         check_eq("bp_valid",    32'(a_if.out_valid), 32'd1);
         check_eq("bp_tag",      32'(a_if.out_tag),   32'd0);
         check_eq("bp_res",      a_if.res,            32'h11);
         check_eq("bp_b_res",    b_if.res,            32'h11);
      end
      @(negedge clk);
      set_ordy32(1'b1);
      got = 0;
      for (int c = 0; c < 16 && got < 4; c++) begin
         #1;
         acc = a_if.in_valid && a_if.in_ready;
         if (a_if.out_valid) begin
            check_eq("bp_order_tag", 32'(a_if.out_tag), 32'(got));
            check_eq("bp_order_res", a_if.res,          32'(32'h11 + got));
            check_eq("bp_order_ovf", 32'(a_if.ovf),     32'd0);
            check_eq("bp_b_tag",     32'(b_if.out_tag), 32'(got));
            got++;
         end
         @(posedge clk); #1;
         if (acc) drive32(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
         @(negedge clk);
      end
      check_eq("bp_count", 32'(got), 32'd4);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check_eq("bp_nodup", 32'(a_if.out_valid), 32'd0);
      end

      // Reset with three transactions in flight.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive32(1'b1, 32'(32'h100 + k), 32'h1, 1'b0, 4'(8 + k));
         set_ordy32(1'b1);
         @(posedge clk);
      end
      @(negedge clk);
      drive32(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      rst_n = 1'b0;
      #1 check_eq("mid_pre_valid", 32'(a_if.out_valid), 32'd1);
      @(posedge clk); #1;
      check_eq("mid_valid",    32'(a_if.out_valid), 32'd0);
      check_eq("mid_res",      a_if.res,            32'h0);
      check_eq("mid_tag",      32'(a_if.out_tag),   32'd0);
      check_eq("mid_in_ready", 32'(a_if.in_ready),  32'd1);
      check_eq("mid_b_valid",  32'(b_if.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         check_eq("mid_no_stale",   32'(a_if.out_valid), 32'd0);
         check_eq("mid_no_stale_b", 32'(b_if.out_valid), 32'd0);
      end

      // 8-bit sweep with random handshakes against the reference model.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         gen_sm8(o1_8);
         gen_sm8(o2_8);
         s_8  = 1'($urandom_range(0, 1));
         t_8  = 4'($urandom_range(0, 15));
         iv_8 = ($urandom_range(0, 3) != 0);
         or_8 = ($urandom_range(0, 3) != 0);
         drive8(iv_8, o1_8, o2_8, s_8, t_8);
         set_ordy8(or_8);
         #1;
         if (c_if.out_valid && or_8) chk8_pop();
         if (iv_8 && c_if.in_ready) push8(o1_8, o2_8, s_8, t_8);
      end
      @(negedge clk);
      drive8(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      set_ordy8(1'b1);
      for (int k = 0; k < 12 && q8.size() > 0; k++) begin
         #1;
         if (c_if.out_valid) chk8_pop();
         @(negedge clk);
      end
      check_eq("sw_drained", 32'(q8.size()), 32'd0);
      #1 check_eq("sw_idle", 32'(c_if.out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
